// File: rtl/dbnc_defs.sv
// Shared definitions for the debounce front end: FSM state encoding and a
// constant-evaluable ceiling-log2 used to size the debounce counter.
package dbnc_defs;

  localparam logic [1:0] ST_LO  = 2'd0;
  localparam logic [1:0] CHK_HI = 2'd1;
  localparam logic [1:0] ST_HI  = 2'd2;
  localparam logic [1:0] CHK_LO = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic samp
);

  logic [SYNC_STAGES-1:0] s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= '0;
    else     s <= {s[SYNC_STAGES-2:0], d_in};
  end

  assign samp = s[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// Synchronise and debounce a raw input, producing a clean level, registered
// edge pulses and a saturating count of accepted rising edges.
module sync_debounce_edge
  import dbnc_defs::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             cnt_clr,
  output logic             q_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int              DC_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            samp;
  logic [1:0]      state;
  logic [DC_W-1:0] dc;
  logic            accept_rise;
  logic            accept_fall;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .samp (samp)
  );

  // The last confirming sample of a run is the one that flips the level.
  assign accept_rise = (state == CHK_HI) && samp  && (dc == DC_LAST);
  assign accept_fall = (state == CHK_LO) && !samp && (dc == DC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LO;
      dc         <= '0;
      q_stable   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        ST_LO: begin
          if (samp) begin
            state <= CHK_HI;
            dc    <= DC_ONE;
          end
        end
        CHK_HI: begin
          if (!samp) begin
            state <= ST_LO;
            dc    <= '0;
          end else if (accept_rise) begin
            state      <= ST_HI;
            dc         <= '0;
            q_stable   <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            dc <= dc + DC_ONE;
          end
        end
        ST_HI: begin
          if (!samp) begin
            state <= CHK_LO;
            dc    <= DC_ONE;
          end
        end
        CHK_LO: begin
          if (samp) begin
            state <= ST_HI;
            dc    <= '0;
          end else if (accept_fall) begin
            state      <= ST_LO;
            dc         <= '0;
            q_stable   <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            dc <= dc + DC_ONE;
          end
        end
        default: begin
          state <= ST_LO;
          dc    <= '0;
        end
      endcase
    end
  end

  // A clear wins over a coincident rise, so that event is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt <= '0;
    end else if (cnt_clr) begin
      event_cnt <= '0;
    end else if (accept_rise && (event_cnt != CNT_MAX)) begin
      event_cnt <= event_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: directed scenarios plus random sequences
// compared against a run-length reference model and a downstream flop.
module tb_sync_debounce_edge;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_in;
  logic       cnt_clr;
  logic       q_stable, rise_pulse, fall_pulse;
  logic [7:0] event_cnt;
  logic       q_stable2, rise_pulse2, fall_pulse2;
  logic [1:0] event_cnt2;

  int checks   = 0;
  int failures = 0;

  sync_debounce_edge #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cnt_clr(cnt_clr),
    .q_stable(q_stable), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_cnt(event_cnt)
  );

  sync_debounce_edge #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .d_in(d_in), .cnt_clr(cnt_clr),
    .q_stable(q_stable2), .rise_pulse(rise_pulse2), .fall_pulse(fall_pulse2),
    .event_cnt(event_cnt2)
  );

  always #5 clk = ~clk;

  // Downstream D flop fed by the debounced level.
  logic ff_dut;
  always @(posedge clk or posedge rst) begin
    if (rst) ff_dut <= 1'b0;
    else     ff_dut <= q_stable;
  end

  // Reference: the FSM sees d_in delayed by SYNC edges; the level flips once
  // DEB consecutive samples disagree with it.
  logic [SYNC-1:0] m_pipe;
  logic m_samp, m_q, m_rp, m_fp, m_ff;
  int   m_run, m_cnt, m_cnt2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pipe = '0;
      m_q = 1'b0; m_rp = 1'b0; m_fp = 1'b0; m_ff = 1'b0;
      m_run = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_samp = m_pipe[SYNC-1];
      m_pipe = {m_pipe[SYNC-2:0], d_in};
      m_ff = m_q;
      m_rp = 1'b0;
      m_fp = 1'b0;
      if (m_samp != m_q) begin
        m_run++;
        if (m_run == DEB) begin
          m_q = ~m_q;
          m_run = 0;
          if (m_q) m_rp = 1'b1;
          else     m_fp = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      if (cnt_clr) begin
        m_cnt = 0;
        m_cnt2 = 0;
      end else if (m_rp) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; d_in = 1'b0; cnt_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({q_stable, rise_pulse, fall_pulse} !== 3'b000 || event_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_hold got q/r/f=%b%b%b cnt=%0d exp 000 cnt=0",
               q_stable, rise_pulse, fall_pulse, event_cnt);
    end
    rst = 1'b0;
    d_in = 1'b1; repeat (10) tick();
    d_in = 1'b0; repeat (10) tick();
    d_in = 1'b1; repeat (4) tick();
    checks++;
    if (event_cnt !== 8'd1 || q_stable !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre got q=%b cnt=%0d exp q=0 cnt=1", q_stable, event_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({q_stable, rise_pulse, fall_pulse} !== 3'b000 || event_cnt !== 8'd0 ||
        event_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_async got q/r/f=%b%b%b cnt=%0d cnt2=%0d exp all 0",
               q_stable, rise_pulse, fall_pulse, event_cnt, event_cnt2);
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (rise_pulse !== (n == 6) || q_stable !== (n >= 6) ||
          event_cnt !== ((n >= 6) ? 8'd1 : 8'd0)) begin
        failures++;
        $display("FAIL reset_release edge %0d got r=%b q=%b cnt=%0d exp r=%b q=%b cnt=%0d",
                 n, rise_pulse, q_stable, event_cnt, (n == 6), (n >= 6), (n >= 6));
      end
    end
  endtask

  task automatic test_rise_fall();
    d_in = 1'b0; repeat (10) tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    checks++;
    if (event_cnt !== 8'd0 || q_stable !== 1'b0) begin
      failures++;
      $display("FAIL rf_clear got q=%b cnt=%0d exp q=0 cnt=0", q_stable, event_cnt);
    end
    d_in = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (q_stable !== (n >= 6) || rise_pulse !== (n == 6) || fall_pulse !== 1'b0) begin
        failures++;
        $display("FAIL rf_rise edge %0d got q=%b r=%b f=%b exp q=%b r=%b f=0",
                 n, q_stable, rise_pulse, fall_pulse, (n >= 6), (n == 6));
      end
    end
    d_in = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (q_stable !== (n < 6) || fall_pulse !== (n == 6) || rise_pulse !== 1'b0) begin
        failures++;
        $display("FAIL rf_fall edge %0d got q=%b r=%b f=%b exp q=%b r=0 f=%b",
                 n, q_stable, rise_pulse, fall_pulse, (n < 6), (n == 6));
      end
    end
    checks++;
    if (event_cnt !== 8'd1) begin
      failures++;
      $display("FAIL rf_cnt got %0d exp 1", event_cnt);
    end
  endtask

  task automatic test_glitch();
    for (int w = 3; w <= 4; w++) begin
      int  rises, falls;
      logic saw_hi;
      rises = 0; falls = 0; saw_hi = 1'b0;
      d_in = 1'b0;
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      for (int n = 0; n < w + 14; n++) begin
        d_in = (n < w);
        tick();
        if (rise_pulse === 1'b1) rises++;
        if (fall_pulse === 1'b1) falls++;
        if (q_stable === 1'b1) saw_hi = 1'b1;
      end
      checks++;
      if (rises != ((w >= DEB) ? 1 : 0) || falls != ((w >= DEB) ? 1 : 0) ||
          saw_hi !== (w >= DEB) || event_cnt !== ((w >= DEB) ? 8'd1 : 8'd0)) begin
        failures++;
        $display("FAIL glitch w=%0d got rises=%0d falls=%0d hi=%b cnt=%0d exp %0d/%0d/%b/%0d",
                 w, rises, falls, saw_hi, event_cnt, (w >= DEB), (w >= DEB), (w >= DEB),
                 (w >= DEB));
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    int rises, rise_edge;
    pat = 9'b111101101;  // bit 0 applied first: 1,0,1,1,0,1,1,1,1
    rises = 0; rise_edge = -1;
    d_in = 1'b0;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      d_in = (n <= 9) ? pat[n-1] : 1'b1;
      tick();
      if (rise_pulse === 1'b1) begin
        rises++;
        rise_edge = n;
      end
    end
    checks++;
    if (rises != 1 || rise_edge != 11 || event_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bounce got rises=%0d edge=%0d cnt=%0d exp 1/11/1",
               rises, rise_edge, event_cnt);
    end
    d_in = 1'b0; repeat (10) tick();
  endtask

  task automatic test_counter();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_in = 1'b1; repeat (8) tick();
      checks++;
      if (event_cnt2 !== exp2[i] || event_cnt !== 8'(i + 1)) begin
        failures++;
        $display("FAIL counter_sat rise %0d got cnt2=%0d cnt=%0d exp %0d/%0d",
                 i + 1, event_cnt2, event_cnt, exp2[i], i + 1);
      end
      d_in = 1'b0; repeat (8) tick();
    end
    d_in = 1'b1; repeat (5) tick();
    checks++;
    if (rise_pulse !== 1'b0 || event_cnt !== 8'd5) begin
      failures++;
      $display("FAIL counter_pre got r=%b cnt=%0d exp r=0 cnt=5", rise_pulse, event_cnt);
    end
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    checks++;
    if (rise_pulse !== 1'b1 || event_cnt !== 8'd0 || event_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL counter_clr_prio got r=%b cnt=%0d cnt2=%0d exp r=1 cnt=0 cnt2=0",
               rise_pulse, event_cnt, event_cnt2);
    end
    tick();
    checks++;
    if (event_cnt !== 8'd0) begin
      failures++;
      $display("FAIL counter_after_clr got %0d exp 0", event_cnt);
    end
    d_in = 1'b0; repeat (8) tick();
  endtask

  task automatic test_random();
    for (int seq = 0; seq < 10; seq++) begin
      int cyc;
      cyc = 0;
      while (cyc < 60) begin
        logic lvl;
        int   len;
        lvl = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) begin
          d_in = lvl;
          cnt_clr = ($urandom_range(0, 15) == 0);
          tick();
          cyc++;
          checks++;
          if (q_stable !== m_q || rise_pulse !== m_rp || fall_pulse !== m_fp ||
              event_cnt !== 8'(m_cnt) || event_cnt2 !== 2'(m_cnt2)) begin
            failures++;
            $display("FAIL rand_outputs seq %0d cyc %0d got q=%b r=%b f=%b cnt=%0d cnt2=%0d exp q=%b r=%b f=%b cnt=%0d cnt2=%0d",
                     seq, cyc, q_stable, rise_pulse, fall_pulse, event_cnt, event_cnt2,
                     m_q, m_rp, m_fp, m_cnt, m_cnt2);
          end
          checks++;
          if (ff_dut !== m_ff || (rise_pulse & fall_pulse) !== 1'b0) begin
            failures++;
            $display("FAIL rand_flop seq %0d cyc %0d got ff=%b r&f=%b exp ff=%b r&f=0",
                     seq, cyc, ff_dut, rise_pulse & fall_pulse, m_ff);
          end
        end
      end
    end
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise_fall();
    test_glitch();
    test_bounce();
    test_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
